// File: rtl/maverickOne_pkg.sv
// maverickOne_pkg: shared register-file sizing and types for the maverickOne issue path
package maverickOne_pkg;
  localparam int NUM_REGS = 32;
  localparam int XLEN = 32;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0] locks_t;
endpackage

// File: rtl/reg_lock_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; pointer moves past the last handshaken requester
module rr_arbiter #(
  parameter int NUM_WB = 3
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              clear_i,
  input  logic [NUM_WB-1:0] req_i,
  input  logic [NUM_WB-1:0] hs_i,
  output logic [NUM_WB-1:0] gnt_o
);
  localparam int PW = $clog2(NUM_WB);
  logic [PW-1:0] rr_q, rr_d;
  logic found;
  function automatic int wrap(input int v);
    return v >= NUM_WB ? v - NUM_WB : v;
  endfunction
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_WB; i++)
      if (!found && req_i[wrap(int'(rr_q) + i)]) begin
        gnt_o[wrap(int'(rr_q) + i)] = 1'b1;
        found = 1'b1;
      end
  end
  always_comb begin
    rr_d = rr_q;
    for (int k = 0; k < NUM_WB; k++)
      if (hs_i[k]) rr_d = PW'(wrap(k + 1));
    if (clear_i) rr_d = '0;
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) rr_q <= '0;
    else rr_q <= rr_d;
endmodule

// File: rtl/reg_lock_ctrl.sv
// reg_lock_ctrl: register-lock scoreboard plus round-robin writeback arbiter onto one RF write port.
// Define REG_LOCK_CTRL_ZERO_REG_EN to make register 0 hard-zero (never locked, never written).
module reg_lock_ctrl #(
  parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter int NUM_WB = 3,
  parameter int XLEN = maverickOne_pkg::XLEN
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic                                clear_i,
  input  logic                                launch_valid_i,
  input  logic                                launch_ready_i,
  input  logic                                launch_wr_i,
  input  logic [$clog2(NUM_REGS)-1:0]         launch_rd_i,
  input  logic [NUM_WB-1:0]                   wb_valid_i,
  input  logic [NUM_WB*$clog2(NUM_REGS)-1:0]  wb_rd_i,
  input  logic [NUM_WB*XLEN-1:0]              wb_data_i,
  output logic [NUM_WB-1:0]                   wb_ready_o,
  output logic                                rf_wr_en_o,
  output logic [$clog2(NUM_REGS)-1:0]         rf_wr_addr_o,
  output logic [XLEN-1:0]                     rf_wr_data_o,
  output logic [NUM_REGS-1:0]                 locks_o,
  output logic                                busy_o
);
  localparam int RW = $clog2(NUM_REGS);
`ifdef REG_LOCK_CTRL_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif
  logic [NUM_REGS-1:0] locks_q, locks_d;
  logic                wr_v_q, wr_v_d;
  logic [RW-1:0]       wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;
  rr_arbiter #(.NUM_WB(NUM_WB)) u_arb (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .clear_i (clear_i),
    .req_i   (wb_valid_i & {NUM_WB{~(clear_i | arst_i)}}),
    .hs_i    (wb_ready_o),
    .gnt_o   (wb_ready_o)
  );
  always_comb begin
    wr_addr_d = '0;
    wr_data_d = '0;
    for (int k = 0; k < NUM_WB; k++)
      if (wb_ready_o[k]) begin
        wr_addr_d = wb_rd_i[k*RW +: RW];
        wr_data_d = wb_data_i[k*XLEN +: XLEN];
      end
    wr_v_d = |wb_ready_o && !(ZeroReg && wr_addr_d == '0);
  end
  // Set is applied after release so a same-edge relaunch keeps the register locked.
  always_comb begin
    locks_d = locks_q;
    if (wr_v_q) locks_d[wr_addr_q] = 1'b0;
    if (launch_valid_i && launch_ready_i && launch_wr_i) locks_d[launch_rd_i] = 1'b1;
    if (ZeroReg) locks_d[0] = 1'b0;
    if (clear_i) locks_d = '0;
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      locks_q   <= '0;
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      locks_q <= locks_d;
      wr_v_q  <= wr_v_d;
      if (|wb_ready_o) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
      end
    end
  assign rf_wr_en_o   = wr_v_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;
  assign locks_o      = locks_q;
  assign busy_o       = |locks_q | wr_v_q;
endmodule

// File: tb/tb_reg_lock_ctrl.sv
// tb_reg_lock_ctrl: directed and random checks of reg_lock_ctrl against a behavioural scoreboard model
module tb_reg_lock_ctrl;
  localparam int NR = 32, XL = 32, NW = 3, RW = 5;
`ifdef REG_LOCK_CTRL_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0, arst_i = 1'b1, clear_i = 1'b0;
  logic launch_valid_i = 1'b0, launch_ready_i = 1'b0, launch_wr_i = 1'b0;
  logic [RW-1:0] launch_rd_i = '0;
  logic [NW-1:0] wb_valid_i = '0;
  logic [NW*RW-1:0] wb_rd_i = '0;
  logic [NW*XL-1:0] wb_data_i = '0;
  logic [NW-1:0] wb_ready_o;
  logic rf_wr_en_o, busy_o;
  logic [RW-1:0] rf_wr_addr_o;
  logic [XL-1:0] rf_wr_data_o;
  logic [NR-1:0] locks_o;
  logic [NR-1:0] m_locks;
  int m_rr;
  logic m_wv;
  logic [RW-1:0] m_wa;
  logic [XL-1:0] m_wd;
  logic [NW-1:0] g_seen;
  int n_cmp = 0, n_err = 0;

  reg_lock_ctrl #(.NUM_REGS(NR), .NUM_WB(NW), .XLEN(XL)) dut (
    .clk_i(clk), .arst_i(arst_i), .clear_i(clear_i),
    .launch_valid_i(launch_valid_i), .launch_ready_i(launch_ready_i),
    .launch_wr_i(launch_wr_i), .launch_rd_i(launch_rd_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o), .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o),
    .rf_wr_data_o(rf_wr_data_o), .locks_o(locks_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_locks = '0; m_rr = 0; m_wv = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic [NW-1:0] exp_grant();
    if (clear_i || arst_i) return '0;
    for (int i = 0; i < NW; i++)
      if (wb_valid_i[(m_rr + i) % NW]) return NW'(1) << ((m_rr + i) % NW);
    return '0;
  endfunction

  // Compare every output against the model, then advance one clock and update the model.
  task automatic step(input string tag);
    logic [NW-1:0] eg;
    logic [NR-1:0] nl;
    int k;
    #1;
    eg = exp_grant();
    g_seen = wb_ready_o;
    chk({tag, ":gnt"}, wb_ready_o, eg);
    chk({tag, ":en"}, rf_wr_en_o, m_wv);
    chk({tag, ":addr"}, rf_wr_addr_o, m_wa);
    chk({tag, ":data"}, rf_wr_data_o, m_wd);
    chk({tag, ":locks"}, locks_o, m_locks);
    chk({tag, ":busy"}, busy_o, (|m_locks) | m_wv);
    @(posedge clk);
    nl = m_locks;
    if (m_wv) nl[m_wa] = 1'b0;
    if (launch_valid_i && launch_ready_i && launch_wr_i) nl[launch_rd_i] = 1'b1;
    if (ZR) nl[0] = 1'b0;
    if (clear_i) begin
      nl = '0; m_wv = 1'b0; m_rr = 0;
    end else if (eg != 0) begin
      k = 0;
      for (int i = 0; i < NW; i++) if (eg[i]) k = i;
      m_wa = wb_rd_i[k*RW +: RW];
      m_wd = wb_data_i[k*XL +: XL];
      m_wv = !(ZR && m_wa == 0);
      m_rr = (k + 1) % NW;
    end else m_wv = 1'b0;
    m_locks = nl;
    @(negedge clk);
  endtask

  task automatic launch(input logic [RW-1:0] rd);
    launch_valid_i = 1'b1; launch_ready_i = 1'b1; launch_wr_i = 1'b1; launch_rd_i = rd;
  endtask

  task automatic no_launch();
    launch_valid_i = 1'b0; launch_ready_i = 1'b0; launch_wr_i = 1'b0;
  endtask

  initial begin
    mreset();
    @(negedge clk); @(negedge clk);
    chk("rst_locks", locks_o, 0);
    chk("rst_en", rf_wr_en_o, 0);
    chk("rst_busy", busy_o, 0);
    arst_i = 1'b0;
    // launch rd=5, writeback from requester 1 two cycles later
    launch(5); step("l5");
    chk("l5_lock", locks_o[5], 1);
    no_launch(); step("idle5");
    wb_valid_i = 3'b010; wb_rd_i[RW +: RW] = 5; wb_data_i[XL +: XL] = 32'hDEAD;
    step("wb5");
    chk("wb5_gnt", g_seen, 3'b010);
    wb_valid_i = '0;
    chk("wb5_en", rf_wr_en_o, 1);
    chk("wb5_addr", rf_wr_addr_o, 5);
    chk("wb5_data", rf_wr_data_o, 32'hDEAD);
    chk("wb5_lock_held", locks_o[5], 1);
    step("w5");
    chk("w5_lock_free", locks_o[5], 0);
    // asynchronous reset mid-cycle with locks 0xF0
    for (int r = 4; r < 8; r++) begin launch(RW'(r)); step("lf0"); end
    no_launch();
    chk("lf0_locks", locks_o, 32'hF0);
    wb_valid_i = 3'b111;
    #2 arst_i = 1'b1;
    #1;
    chk("arst_locks", locks_o, 0);
    chk("arst_en", rf_wr_en_o, 0);
    chk("arst_addr", rf_wr_addr_o, 0);
    chk("arst_data", rf_wr_data_o, 0);
    chk("arst_gnt", wb_ready_o, 0);
    chk("arst_busy", busy_o, 0);
    @(negedge clk);
    arst_i = 1'b0; mreset();
    // all requesters valid from reset: grant order 0,1,2,0,1,2
    wb_rd_i = {RW'(3), RW'(2), RW'(1)};
    for (int i = 0; i < 6; i++) begin
      step("rr");
      chk("rr_order", g_seen, NW'(1) << (i % 3));
    end
    wb_valid_i = '0; step("drain");
    // release of rd=7 coincides with a new launch of rd=7
    launch(7); step("l7");
    no_launch(); wb_valid_i = 3'b001; wb_rd_i[0 +: RW] = 7; wb_data_i[0 +: XL] = 32'h77;
    step("wb7");
    wb_valid_i = '0; launch(7);
    chk("r7_en", rf_wr_en_o, 1);
    step("r7");
    no_launch();
    chk("r7_lock_kept", locks_o[7], 1);
    wb_valid_i = 3'b001; step("wb7b");
    wb_valid_i = '0; step("w7b"); step("w7c");
    chk("w7_lock_free", locks_o[7], 0);
    // clear with locks 0xFFFF and the write stage valid
    for (int r = 0; r < 16; r++) begin
      launch(RW'(r));
      if (r == 15) begin wb_valid_i = 3'b100; wb_rd_i[2*RW +: RW] = 20; wb_data_i[2*XL +: XL] = 32'hC1EA; end
      step("lff");
    end
    no_launch();
    chk("lff_locks", locks_o, ZR ? 32'hFFFE : 32'hFFFF);
    chk("lff_en", rf_wr_en_o, 1);
    clear_i = 1'b1; wb_valid_i = 3'b111; launch(9);
    #1 chk("clr_gnt", wb_ready_o, 0);
    step("clr");
    clear_i = 1'b0; no_launch(); wb_valid_i = '0;
    chk("clr_locks", locks_o, 0);
    chk("clr_en", rf_wr_en_o, 0);
`ifdef REG_LOCK_CTRL_ZERO_REG_EN
    launch(0); step("z0");
    no_launch();
    chk("z0_lock", locks_o[0], 0);
    wb_valid_i = 3'b100; wb_rd_i[2*RW +: RW] = 0;
    step("zwb");
    chk("zwb_gnt", g_seen, 3'b100);
    wb_valid_i = '0;
    chk("zwb_en", rf_wr_en_o, 0);
    step("zdone");
`endif
    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      launch_valid_i = 1'($urandom); launch_ready_i = 1'($urandom); launch_wr_i = 1'($urandom);
      launch_rd_i = RW'($urandom);
      wb_valid_i = NW'($urandom);
      wb_rd_i = (NW*RW)'({$urandom, $urandom});
      wb_data_i = {$urandom, $urandom, $urandom};
      clear_i = ($urandom_range(0, 31) == 0);
      step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_lock_ctrl.md
# reg_lock_ctrl

Register-lock scoreboard and writeback arbiter for the maverickOne issue path. It sets a per-register lock when the instruction launcher hands off an instruction that writes `rd`. It arbitrates up to `NUM_WB` execution-unit writeback requesters round-robin onto the single register-file write port, and releases each lock when its write commits. Its `locks_o` vector is the lock profile fed to the launcher's `locks_i`.

## Interface
Parameters:
- `NUM_REGS`, `maverickOne_pkg::NUM_REGS`, number of architectural registers
- `NUM_WB`, 3, number of writeback requesters (≥2)
- `XLEN`, `maverickOne_pkg::XLEN`, data width

Ports:
- `clk_i`  in  1  clock (single clock domain)
- `arst_i`  in  1  asynchronous reset, active-high
- `clear_i`  in  1  synchronous flush
- `launch_valid_i`  in  1  launcher output valid
- `launch_ready_i`  in  1  downstream ready; a launch fires on `launch_valid_i & launch_ready_i`
- `launch_wr_i`  in  1  launched instruction writes `rd`
- `launch_rd_i`  in  `$clog2(NUM_REGS)`  destination register
- `wb_valid_i`  in  `NUM_WB`  writeback requests
- `wb_rd_i`  in  `NUM_WB × $clog2(NUM_REGS)`  writeback addresses
- `wb_data_i`  in  `NUM_WB × XLEN`  writeback data
- `wb_ready_o`  out  `NUM_WB`  one-hot grant
- `rf_wr_en_o`  out  1  register-file write enable
- `rf_wr_addr_o`  out  `$clog2(NUM_REGS)`  register-file write address
- `rf_wr_data_o`  out  `XLEN`  register-file write data
- `locks_o`  out  `NUM_REGS`  current lock vector
- `busy_o`  out  1  `|locks_o | rf_wr_en_o`

## Operation
- **Lock set:** at each edge where a launch fires with `launch_wr_i=1`, set `lock[launch_rd_i]`. Setting an already-set bit is idempotent.
- **Arbitration:** combinational round-robin over `wb_valid_i`, starting at pointer `rr_q`.
  - `wb_ready_o` is the one-hot grant: at most one bit high, and only for a valid requester.
  - A handshake on requester k advances `rr_q` to (k+1) mod `NUM_WB`.
  - With no request, `rr_q` holds.
- **Write stage:** a one-entry register loaded from the granted requester. It drives `rf_wr_*_o`. `rf_wr_en_o` equals the stage-valid bit. The register file never back-pressures.
- **Lock release:** at the edge ending a cycle with `rf_wr_en_o=1`, clear `lock[rf_wr_addr_o]`.
- **Set and release on the same register at the same edge:** set wins, so the register stays locked for the new writer.
- **Writeback to an unlocked register:** the write is performed; the lock is unchanged.
- **clear_i:** at the next edge, clear all locks, invalidate the write stage and reset `rr_q` to 0. While `clear_i=1`, `wb_ready_o` is 0 and a concurrent launch does not set a lock. A pending write-stage entry is dropped.
- **Reset (`arst_i=1`, asynchronous):** `locks_o=0`, `rf_wr_en_o=0`, `rf_wr_addr_o=0`, `rf_wr_data_o=0`, `wb_ready_o=0`, `busy_o=0`, `rr_q=0`.
- **Reset mid-operation:** in-flight writes and all locks are discarded.

## Timing
- `wb_ready_o` is combinational from `wb_valid_i`, `rr_q` and `clear_i`. Requesters must not make `wb_valid_i` depend on `wb_ready_o`.
- Write sequence for a grant in cycle N:
  - cycle N+1: `rf_wr_en_o=1`, register file writes at the N+1→N+2 edge;
  - cycle N+2: the lock bit reads 0.
- `locks_o` is driven directly from flops. A lock set by a launch at the N→N+1 edge is visible in cycle N+1.
- Throughput: one writeback per cycle.

## Configuration
- `REG_LOCK_CTRL_ZERO_REG_EN` **defined:** register 0 is hard-zero.
  - `lock[0]` is never set and `locks_o[0]` is constant 0.
  - A writeback to register 0 is still granted, but `rf_wr_en_o` stays 0 for it.
- **Undefined:** register 0 is treated like every other register.

## Structure
- `maverickOne_pkg` holds:
  - `NUM_REGS` and `XLEN`;
  - `reg_idx_t` (`logic [$clog2(NUM_REGS)-1:0]`);
  - `locks_t` (`logic [NUM_REGS-1:0]`).
- The round-robin logic is a natural sub-module, `rr_arbiter`, parameterised by `NUM_WB`. It takes request and handshake inputs and gives a one-hot grant output.
- Lock flops and the write stage stay in `reg_lock_ctrl`.

## Test plan
- Reset: assert `arst_i` mid-clock with locks 0x0000_00F0 → all outputs 0 immediately. After release, `locks_o=0`.
- Launch `rd=5`, then writeback `rd=5`, `data=0xDEAD` from requester 1 two cycles later → `locks_o[5]` high from the launch cycle+1. `rf_wr_en_o=1`, addr 5, data 0xDEAD one cycle after the grant. `locks_o[5]` low the following cycle.
- All three requesters valid for 6 cycles from reset → grants in order 0,1,2,0,1,2.
- Release of `rd=7` in the same cycle as a launch with `rd=7` → `locks_o[7]` stays 1.
- `clear_i` pulse with locks 0xFFFF and the write stage valid → next cycle `locks_o=0` and `rf_wr_en_o=0`. During the clear cycle, `wb_ready_o=0`.
- With `REG_LOCK_CTRL_ZERO_REG_EN`: launch `rd=0`, then writeback `rd=0` → `locks_o[0]` stays 0, the requester is granted, and `rf_wr_en_o` stays 0.
